// File: rtl/run_state_ctrl.sv
// Game-flow controller: sequences the collision checker and owns
// lives, invulnerability window, distance score and speed level.
module run_state_ctrl #(
  parameter int OBST_LANE     = 1,
  parameter int LIVES         = 3,
  parameter int LIFE_WIDTH    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int INV_WIDTH     = 8,
  parameter int SCORE_WIDTH   = 32,
  parameter int LEVEL_STEP    = 500,
  parameter int MAX_LEVEL     = 7,
  parameter int LEVEL_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [OBST_LANE-1:0]   has_collision,
  output logic                   ignore_obstacle,
  output logic                   rst_count,
  output logic [LIFE_WIDTH-1:0]  lives,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [LEVEL_WIDTH-1:0] speed_level,
  output logic                   hit_pulse,
  output logic                   invuln,
  output logic                   game_over,
  output logic [1:0]             state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam int LCW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  localparam logic [LCW-1:0] LC_LAST =
    LCW'(LEVEL_STEP - 1);
  localparam logic [LIFE_WIDTH-1:0] LIVES_INIT =
    LIFE_WIDTH'(LIVES);
  localparam logic [INV_WIDTH-1:0] INV_INIT =
    INV_WIDTH'(INVULN_FRAMES);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX =
    LEVEL_WIDTH'(MAX_LEVEL);

  logic                   collision;
  logic                   scoring;
  logic [INV_WIDTH-1:0]   inv_cnt;
  logic [LCW-1:0]         level_cnt;

  logic [1:0]             state_d;
  logic [LIFE_WIDTH-1:0]  lives_d;
  logic [SCORE_WIDTH-1:0] score_d;
  logic [LEVEL_WIDTH-1:0] level_d;
  logic [LCW-1:0]         lc_d;
  logic [INV_WIDTH-1:0]   inv_d;
  logic                   hit_d;

  assign collision = |has_collision;
  assign scoring   = frame_tick &&
                     (state == S_RUN || state == S_HIT);

  always_comb begin
    state_d = state;
    lives_d = lives;
    score_d = score;
    level_d = speed_level;
    lc_d    = level_cnt;
    inv_d   = inv_cnt;
    hit_d   = 1'b0;

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          lives_d = LIVES_INIT;
          score_d = '0;
          level_d = '0;
          lc_d    = '0;
          inv_d   = '0;
        end
      end
      S_RUN: begin
        // collision outranks start; start is simply not looked at here
        if (collision) begin
          hit_d = 1'b1;
          if (lives > LIFE_WIDTH'(1)) begin
            state_d = S_HIT;
            lives_d = lives - LIFE_WIDTH'(1);
            inv_d   = INV_INIT;
          end else begin
            state_d = S_OVER;
            lives_d = '0;
          end
        end
      end
      default: begin
        if (frame_tick) begin
          if (inv_cnt <= INV_WIDTH'(1)) begin
            state_d = S_RUN;
            inv_d   = '0;
          end else begin
            inv_d = inv_cnt - INV_WIDTH'(1);
          end
        end
      end
    endcase

    if (scoring) begin
      if (!(&score))
        score_d = score + SCORE_WIDTH'(1);
      if (level_cnt == LC_LAST) begin
        lc_d = '0;
        if (speed_level < LVL_MAX)
          level_d = speed_level + LEVEL_WIDTH'(1);
      end else begin
        lc_d = level_cnt + LCW'(1);
      end
    end
  end

  // flags are decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      lives           <= LIVES_INIT;
      score           <= '0;
      speed_level     <= '0;
      level_cnt       <= '0;
      inv_cnt         <= '0;
      hit_pulse       <= 1'b0;
      ignore_obstacle <= 1'b1;
      rst_count       <= 1'b1;
      invuln          <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      state           <= state_d;
      lives           <= lives_d;
      score           <= score_d;
      speed_level     <= level_d;
      level_cnt       <= lc_d;
      inv_cnt         <= inv_d;
      hit_pulse       <= hit_d;
      ignore_obstacle <= (state_d != S_RUN);
      rst_count       <= (state_d == S_IDLE) ||
                         (state_d == S_OVER);
      invuln          <= (state_d == S_HIT);
      game_over       <= (state_d == S_OVER);
    end
  end

endmodule

// File: tb/tb_run_state_ctrl.sv
// Bench for run_state_ctrl: directed scenarios plus random play
// against a game-rule reference model.
module tb_run_state_ctrl;

  localparam int LANES = 2;
  localparam int NLIV  = 3;
  localparam int INVF  = 3;
  localparam int SW    = 6;
  localparam int STEP  = 4;
  localparam int MAXL  = 7;
  localparam int SMAX  = (1 << SW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic             start = 1'b0;
  logic [LANES-1:0] has_collision = '0;
  logic             ignore_obstacle;
  logic             rst_count;
  logic [2:0]       lives;
  logic [SW-1:0]    score;
  logic [2:0]       speed_level;
  logic             hit_pulse;
  logic             invuln;
  logic             game_over;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 run, 2 hit, 3 over
  int m_phase;
  int m_lives;
  int m_ticks;
  int m_inv;
  int m_hit;

  run_state_ctrl #(
    .OBST_LANE(LANES), .LIVES(NLIV), .LIFE_WIDTH(3),
    .INVULN_FRAMES(INVF), .INV_WIDTH(8),
    .SCORE_WIDTH(SW), .LEVEL_STEP(STEP),
    .MAX_LEVEL(MAXL), .LEVEL_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_tick(frame_tick), .start(start),
    .has_collision(has_collision),
    .ignore_obstacle(ignore_obstacle),
    .rst_count(rst_count), .lives(lives),
    .score(score), .speed_level(speed_level),
    .hit_pulse(hit_pulse), .invuln(invuln),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0;
    m_lives = NLIV;
    m_ticks = 0;
    m_inv   = 0;
    m_hit   = 0;
  endtask

  task automatic model_step(input bit s, input bit c,
                            input bit t);
    m_hit = 0;
    if (m_phase == 0 || m_phase == 3) begin
      if (s) begin
        m_phase = 1;
        m_lives = NLIV;
        m_ticks = 0;
      end
    end else if (m_phase == 1) begin
      if (t) m_ticks++;
      if (c) begin
        m_hit = 1;
        m_lives--;
        if (m_lives > 0) begin
          m_phase = 2;
          m_inv   = INVF;
        end else begin
          m_phase = 3;
        end
      end
    end else begin
      if (t) begin
        m_ticks++;
        m_inv--;
        if (m_inv == 0) m_phase = 1;
      end
    end
  endtask

  function automatic int exp_score();
    return (m_ticks > SMAX) ? SMAX : m_ticks;
  endfunction

  function automatic int exp_level();
    return (m_ticks / STEP > MAXL) ? MAXL : m_ticks / STEP;
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [18:0] v;
    v = {2'(m_phase), 3'(m_lives), 6'(exp_score()),
         3'(exp_level()), m_hit != 0, m_phase == 2,
         m_phase == 3, m_phase != 1,
         (m_phase == 0 || m_phase == 3)};
    return v;
  endfunction

  wire [18:0] act_vec = {state, lives, score, speed_level,
                         hit_pulse, invuln, game_over,
                         ignore_obstacle, rst_count};

  task automatic cyc(input bit s, input logic [LANES-1:0] c,
                     input bit t);
    start = s;
    has_collision = c;
    frame_tick = t;
    @(posedge clk);
    model_step(s, |c, t);
    #1;
    start = 1'b0;
    has_collision = '0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, '0, 1);
      if ($urandom_range(1, 0) == 1) cyc(0, '0, 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_vec got %h exp %h",
               act_vec, exp_vec());
    end
    rst_n = 1'b1;
    cyc(0, '0, 1);
    checks++;
    if (state !== 2'd0 || score !== '0) begin
      errors++;
      $display("FAIL idle_hold state %0d score %0d exp 0 0",
               state, score);
    end
  endtask

  task automatic test_start();
    cyc(1, '0, 0);
    checks++;
    if (state !== 2'd1 || lives !== 3'd3 ||
        ignore_obstacle !== 1'b0 || rst_count !== 1'b0 ||
        score !== '0) begin
      errors++;
      $display("FAIL start st %0d lv %0d ig %0d rc %0d sc %0d exp 1 3 0 0 0",
               state, lives, ignore_obstacle, rst_count, score);
    end
  endtask

  task automatic test_score_level();
    ticks(8);
    checks++;
    if (score !== 6'd8 || speed_level !== 3'd2) begin
      errors++;
      $display("FAIL level8 score %0d lvl %0d exp 8 2",
               score, speed_level);
    end
    ticks(2);
    checks++;
    if (score !== 6'd10) begin
      errors++;
      $display("FAIL score10 got %0d exp 10", score);
    end
    ticks(18);
    checks++;
    if (speed_level !== 3'd7) begin
      errors++;
      $display("FAIL level28 got %0d exp 7", speed_level);
    end
    ticks(5);
    checks++;
    if (speed_level !== 3'd7 || score !== 6'd33) begin
      errors++;
      $display("FAIL level_sat lvl %0d score %0d exp 7 33",
               speed_level, score);
    end
  endtask

  task automatic test_saturation();
    ticks(40);
    checks++;
    if (score !== 6'(SMAX)) begin
      errors++;
      $display("FAIL score_sat got %0d exp %0d", score, SMAX);
    end
  endtask

  task automatic test_hit();
    cyc(0, 2'b01, 0);
    checks++;
    if (state !== 2'd2 || lives !== 3'd2 ||
        hit_pulse !== 1'b1 || ignore_obstacle !== 1'b1 ||
        invuln !== 1'b1) begin
      errors++;
      $display("FAIL hit st %0d lv %0d hp %0d ig %0d inv %0d exp 2 2 1 1 1",
               state, lives, hit_pulse, ignore_obstacle, invuln);
    end
    cyc(0, 2'b01, 0);
    checks++;
    if (hit_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_once got %0d exp 0", hit_pulse);
    end
    repeat (3) cyc(0, 2'b01, 0);
    checks++;
    if (lives !== 3'd2 || state !== 2'd2) begin
      errors++;
      $display("FAIL hit_held lv %0d st %0d exp 2 2",
               lives, state);
    end
    ticks(2);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL inv_early st %0d exp 2", state);
    end
    ticks(1);
    checks++;
    if (state !== 2'd1 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL inv_end st %0d inv %0d exp 1 0",
               state, invuln);
    end
  endtask

  task automatic test_game_over();
    cyc(0, 2'b10, 0);
    ticks(3);
    checks++;
    if (lives !== 3'd1 || state !== 2'd1) begin
      errors++;
      $display("FAIL second_hit lv %0d st %0d exp 1 1",
               lives, state);
    end
    cyc(0, 2'b11, 0);
    checks++;
    if (state !== 2'd3 || lives !== 3'd0 ||
        game_over !== 1'b1 || hit_pulse !== 1'b1 ||
        rst_count !== 1'b1) begin
      errors++;
      $display("FAIL over st %0d lv %0d go %0d hp %0d rc %0d exp 3 0 1 1 1",
               state, lives, game_over, hit_pulse, rst_count);
    end
    ticks(3);
    checks++;
    if (score !== 6'(exp_score())) begin
      errors++;
      $display("FAIL over_frozen got %0d exp %0d",
               score, exp_score());
    end
    cyc(1, '0, 0);
    checks++;
    if (state !== 2'd1 || lives !== 3'd3 || score !== '0 ||
        game_over !== 1'b0 || speed_level !== '0) begin
      errors++;
      $display("FAIL restart st %0d lv %0d sc %0d go %0d exp 1 3 0 0",
               state, lives, score, game_over);
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 2'b01, 1);
    checks++;
    if (state !== 2'd2 || score !== 6'd1) begin
      errors++;
      $display("FAIL col_tick st %0d sc %0d exp 2 1",
               state, score);
    end
    ticks(3);
    cyc(1, 2'b10, 0);
    checks++;
    if (state !== 2'd2 || lives !== 3'd1 ||
        score !== 6'd4) begin
      errors++;
      $display("FAIL start_col st %0d lv %0d sc %0d exp 2 1 4",
               state, lives, score);
    end
  endtask

  task automatic test_async_reset();
    cyc(0, '0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset got %h exp %h",
               act_vec, exp_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    cyc(1, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(7, 0) == 0,
          ($urandom_range(11, 0) == 0) ?
            LANES'($urandom_range(3, 1)) : '0,
          $urandom_range(1, 0) == 1);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random cyc %0d got %h exp %h",
                   i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score_level();
    test_saturation();
    test_hit();
    test_game_over();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
